// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: slew-rate limiter and direction sequencer feeding a pwm lo[7:0].
// The applied duty walks one LSB every STEP_DIV clocks toward the captured
// target. A direction change first brakes the duty to zero, then holds zero
// for DEAD_CYC clocks, and only then flips lo[7].
// Optional emergency stop: define PWM_RAMP_ESTOP_EN to add the estop port.
module pwm_ramp_ctrl #(
  parameter int STEP_DIV = 1000,
  parameter int DEAD_CYC = 5000,
  parameter int DUTY_MAX = 127
) (
  input  logic       clk,
  input  logic       cl,
  input  logic       en,
  input  logic [7:0] cmd,
  input  logic       cmd_vld,
`ifdef PWM_RAMP_ESTOP_EN
  input  logic       estop,
`endif
  output logic [7:0] lo,
  output logic       at_target,
  output logic       busy
);

  localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int DW = (DEAD_CYC > 1) ? $clog2(DEAD_CYC) : 1;
  localparam logic [6:0] CLIP = 7'(DUTY_MAX);

  typedef enum logic [1:0] {S_TRACK, S_BRAKE, S_DEAD} state_t;

  state_t        r_state;
  logic [7:0]    r_lo;
  logic          r_tdir;
  logic [6:0]    r_tmag;
  logic [SW-1:0] r_step_cnt;
  logic [DW-1:0] r_dead_cnt;
  // Set by an emergency stop: the following DEAD must run to completion and
  // must not flip the direction.
  logic          r_eflag;

  logic       w_estop;
  logic [6:0] w_lo_mag;
  logic [6:0] w_cmd_mag;
  logic       w_rev;
  logic [6:0] w_goal;
  logic       w_pend;
  logic       w_up;
  logic       w_step_exp;
  logic       w_dead_exp;

`ifdef PWM_RAMP_ESTOP_EN
  assign w_estop = estop;
`else
  assign w_estop = 1'b0;
`endif

  assign w_lo_mag  = r_lo[6:0];
  assign w_cmd_mag = (cmd[6:0] > CLIP) ? CLIP : cmd[6:0];

  // A reversal is wanted when the target points the other way with a nonzero
  // magnitude. While that holds, the duty is driven toward zero; otherwise it
  // is driven toward the target. Any state change only redirects a count that
  // is already running, so the first step lands STEP_DIV clocks after capture.
  assign w_rev      = (r_tdir != r_lo[7]) && (r_tmag != 7'd0);
  assign w_goal     = w_rev ? 7'd0 : r_tmag;
  assign w_pend     = (w_lo_mag != w_goal) && !((r_state == S_DEAD) && r_eflag);
  assign w_up       = (w_lo_mag < w_goal);
  assign w_step_exp = (r_step_cnt == SW'(STEP_DIV - 1));
  assign w_dead_exp = (r_dead_cnt == DW'(DEAD_CYC - 1));

  assign lo        = r_lo;
  assign at_target = (r_state == S_TRACK) && (w_lo_mag == r_tmag) && (r_lo[7] == r_tdir);
  assign busy      = (r_state == S_BRAKE) || (r_state == S_DEAD);

  // Target capture: independent of en, overridden by an emergency stop.
  always_ff @(posedge clk or posedge cl) begin
    if (cl) begin
      r_tdir <= 1'b0;
      r_tmag <= 7'd0;
    end else if (w_estop) begin
      r_tmag <= 7'd0;
    end else if (cmd_vld) begin
      r_tdir <= cmd[7];
      r_tmag <= w_cmd_mag;
    end
  end

  // Sequencer: step timer, duty stepping, brake/dead/track transitions.
  always_ff @(posedge clk or posedge cl) begin
    if (cl) begin
      r_state    <= S_TRACK;
      r_lo       <= 8'h00;
      r_step_cnt <= '0;
      r_dead_cnt <= '0;
      r_eflag    <= 1'b0;
    end else if (w_estop) begin
      r_lo[6:0]  <= 7'd0;
      r_state    <= S_DEAD;
      r_step_cnt <= '0;
      r_dead_cnt <= '0;
      r_eflag    <= 1'b1;
    end else if (en) begin
      // The step timer runs only while a step is pending. When it expires it
      // wraps and the step is applied. Targets captured on this same edge are
      // not yet visible, so an expiry always acts on the previous target.
      if (w_pend) begin
        if (w_step_exp) begin
          r_step_cnt <= '0;
          r_lo[6:0]  <= w_up ? (w_lo_mag + 7'd1) : (w_lo_mag - 7'd1);
        end else begin
          r_step_cnt <= r_step_cnt + SW'(1);
        end
      end else begin
        r_step_cnt <= '0;
      end

      case (r_state)
        S_TRACK: begin
          if (w_rev) r_state <= S_BRAKE;
        end
        S_BRAKE: begin
          // Lasts exactly one cycle when the duty is already zero.
          if (!w_rev) begin
            r_state <= S_TRACK;
          end else if (w_lo_mag == 7'd0) begin
            r_state    <= S_DEAD;
            r_dead_cnt <= '0;
          end
        end
        S_DEAD: begin
          if (!w_rev && !r_eflag) begin
            // Reversal cancelled: resume tracking in the present direction.
            r_state    <= S_TRACK;
            r_dead_cnt <= '0;
          end else if (w_dead_exp) begin
            if (!r_eflag) r_lo[7] <= r_tdir;
            r_state    <= S_TRACK;
            r_dead_cnt <= '0;
            r_eflag    <= 1'b0;
          end else begin
            r_dead_cnt <= r_dead_cnt + DW'(1);
          end
        end
        default: r_state <= S_TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Directed bench for pwm_ramp_ctrl (STEP_DIV=4, DEAD_CYC=8). A second instance
// with DUTY_MAX=100 covers clipping and the en freeze.
module tb_pwm_ramp_ctrl;
  logic       clk = 1'b0;
  logic       cl = 1'b1;
  logic       en = 1'b1, en2 = 1'b1;
  logic [7:0] cmd = 8'h00, cmd2 = 8'h00;
  logic       cmd_vld = 1'b0, cmd_vld2 = 1'b0;
  logic [7:0] lo, lo2;
  logic       at_target, at_target2, busy, busy2;
`ifdef PWM_RAMP_ESTOP_EN
  logic       estop = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pwm_ramp_ctrl #(.STEP_DIV(4), .DEAD_CYC(8), .DUTY_MAX(127)) dut (
    .clk(clk), .cl(cl), .en(en), .cmd(cmd), .cmd_vld(cmd_vld),
`ifdef PWM_RAMP_ESTOP_EN
    .estop(estop),
`endif
    .lo(lo), .at_target(at_target), .busy(busy));

  pwm_ramp_ctrl #(.STEP_DIV(4), .DEAD_CYC(8), .DUTY_MAX(100)) dut2 (
    .clk(clk), .cl(cl), .en(en2), .cmd(cmd2), .cmd_vld(cmd_vld2),
`ifdef PWM_RAMP_ESTOP_EN
    .estop(1'b0),
`endif
    .lo(lo2), .at_target(at_target2), .busy(busy2));

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance k rising edges and settle 1 ns past the last one.
  task automatic clks(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  // Strobe a command; returns 1 ns after the capture edge.
  task automatic send(input logic [7:0] c);
    cmd = c; cmd_vld = 1'b1;
    clks(1);
    cmd_vld = 1'b0;
  endtask

  task automatic send2(input logic [7:0] c);
    cmd2 = c; cmd_vld2 = 1'b1;
    clks(1);
    cmd_vld2 = 1'b0;
  endtask

  initial begin
    // reset values
    clks(3);
    cl = 1'b0;
    chk("rst_lo", lo, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);
    chk("rst_at", {7'd0, at_target}, 8'h01);

    // async reset mid-ramp
    send(8'h0A);
    clks(24);
    chk("mid_lo", lo, 8'h06);
    cl = 1'b1;
    #1;
    chk("async_lo", lo, 8'h00);
    chk("async_busy", {7'd0, busy}, 8'h00);
    chk("async_at", {7'd0, at_target}, 8'h01);
    #1 cl = 1'b0;
    clks(12);
    chk("post_rst_lo", lo, 8'h00);

    // ramp up 0 -> 0x0A
    send(8'h0A);
    clks(3);
    chk("up_e3", lo, 8'h00);
    chk("up_e3_at", {7'd0, at_target}, 8'h00);
    clks(1);
    chk("up_e4", lo, 8'h01);
    clks(36);
    chk("up_e40", lo, 8'h0A);
    chk("up_e40_at", {7'd0, at_target}, 8'h01);
    clks(8);
    chk("up_hold", lo, 8'h0A);

    // reversal request, cancelled during the dead time
    send(8'h82);
    clks(1);
    chk("cx_busy1", {7'd0, busy}, 8'h01);
    clks(39);
    chk("cx_e40", lo, 8'h00);
    clks(4);
    chk("cx_dead_lo", lo, 8'h00);
    chk("cx_dead_busy", {7'd0, busy}, 8'h01);
    send(8'h03);
    clks(1);
    chk("cx_f1_busy", {7'd0, busy}, 8'h00);
    chk("cx_f1_lo", lo, 8'h00);
    clks(3);
    chk("cx_f4", lo, 8'h01);
    clks(8);
    chk("cx_f12", lo, 8'h03);
    chk("cx_f12_at", {7'd0, at_target}, 8'h01);

    // back to 0x0A, then full reversal to 0x85
    send(8'h0A);
    clks(28);
    chk("re_0a", lo, 8'h0A);
    send(8'h85);
    clks(1);
    chk("rv_busy1", {7'd0, busy}, 8'h01);
    clks(3);
    chk("rv_e4", lo, 8'h09);
    clks(36);
    chk("rv_e40", lo, 8'h00);
    chk("rv_e40_busy", {7'd0, busy}, 8'h01);
    clks(8);
    chk("rv_e48", lo, 8'h00);
    chk("rv_e48_busy", {7'd0, busy}, 8'h01);
    clks(1);
    chk("rv_e49", lo, 8'h80);
    chk("rv_e49_busy", {7'd0, busy}, 8'h00);
    clks(4);
    chk("rv_e53", lo, 8'h81);
    clks(16);
    chk("rv_e69", lo, 8'h85);
    chk("rv_e69_at", {7'd0, at_target}, 8'h01);

`ifdef PWM_RAMP_ESTOP_EN
    // emergency stop while ramping in the reverse direction
    send(8'hD0);
    clks(300);
    chk("es_pre", lo, 8'hD0);
    estop = 1'b1;
    clks(1);
    estop = 1'b0;
    chk("es_s0_lo", lo, 8'h80);
    chk("es_s0_busy", {7'd0, busy}, 8'h01);
    clks(7);
    chk("es_s7_busy", {7'd0, busy}, 8'h01);
    chk("es_s7_lo", lo, 8'h80);
    clks(1);
    chk("es_s8_busy", {7'd0, busy}, 8'h00);
    chk("es_s8_lo", lo, 8'h80);
    clks(10);
    chk("es_after_lo", lo, 8'h80);
    chk("es_after_at", {7'd0, at_target}, 8'h01);
`endif

    // clip to DUTY_MAX=100 with an en freeze mid-ramp
    send2(8'h7F);
    clks(200);
    chk("clip_g200", lo2, 8'h32);
    clks(2);
    en2 = 1'b0;
    clks(20);
    chk("frz_lo", lo2, 8'h32);
    chk("frz_at", {7'd0, at_target2}, 8'h00);
    en2 = 1'b1;
    clks(1);
    chk("frz_g223", lo2, 8'h32);
    clks(1);
    chk("frz_g224", lo2, 8'h33);
    clks(196);
    chk("clip_top", lo2, 8'h64);
    chk("clip_at", {7'd0, at_target2}, 8'h01);
    clks(20);
    chk("clip_hold", lo2, 8'h64);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
